// File: rtl/packed_cmd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// packed_cmd_arbiter_pkg
//
// Shared definitions for the packed-command link:
//   packed_cmd_s          - one 32-bit link word {w_not_r, addr[22:0], data[7:0]}
//   arb_state_e           - arbiter transaction states
//   default_err_data_lp   - word handed back to a requester whose read timed out
//   cmd_is_write()        - decodes the direction bit of a raw link word
// ---------------------------------------------------------------------------
package packed_cmd_arbiter_pkg;

    localparam int          cmd_width_lp        = 32;
    localparam logic [31:0] default_err_data_lp = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        w_not_r;
        logic [22:0] addr;
        logic [7:0]  data;
    } packed_cmd_s;

    typedef enum logic [1:0] {
        e_idle,
        e_send,
        e_resp,
        e_err
    } arb_state_e;

    function automatic logic cmd_is_write(input logic [cmd_width_lp-1:0] word);
        packed_cmd_s cmd;
        cmd = packed_cmd_s'(word);
        return cmd.w_not_r;
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// ---------------------------------------------------------------------------
// bsg_arb_round_robin
//
// Round-robin arbiter. The grant goes to the first requester with its request
// bit set, searching upward from the requester after the last one granted and
// wrapping around. The pointer only advances when the grant is consumed.
//
// Ports:
//   clk_i     clock
//   reset_i   synchronous active-high reset; requester 0 wins first
//   reqs_i    request bits, one per requester
//   grants_o  one-hot grant (zero when nothing is requested)
//   yumi_i    the current grant has been consumed
// ---------------------------------------------------------------------------
module bsg_arb_round_robin #(
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] reqs_i,
    output logic [width_p-1:0] grants_o,
    input  logic               yumi_i
);

    localparam int idx_w_lp = (width_p > 1) ? $clog2(width_p) : 1;

    logic [idx_w_lp-1:0] last_r;
    logic [idx_w_lp-1:0] grant_idx;
    logic [idx_w_lp-1:0] cand_idx;
    logic                found;
    int                  cand;

    // Walk the requesters starting one past the last winner; the first hit wins.
    always_comb begin
        grants_o  = '0;
        grant_idx = last_r;
        cand_idx  = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 1; i <= width_p; i++) begin
            cand = int'(last_r) + i;
            if (cand >= width_p) begin
                cand = cand - width_p;
            end
            cand_idx = idx_w_lp'(cand);
            if (!found && reqs_i[cand_idx]) begin
                found              = 1'b1;
                grants_o[cand_idx] = 1'b1;
                grant_idx          = cand_idx;
            end
        end
    end

    // Resetting to the highest index makes requester 0 the first winner.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_r <= idx_w_lp'(width_p - 1);
        end else if (yumi_i && found) begin
            last_r <= grant_idx;
        end
    end

endmodule

// File: rtl/packed_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// packed_cmd_arbiter
//
// Shares one packed-command link between num_req_p command producers. Grants
// are round-robin and only one transaction is ever in flight: a command is
// registered, driven downstream, and for reads the arbiter waits for the
// response and routes it back to the requester that issued it. A read that
// sees no response within timeout_p cycles is answered with err_data_p.
//
// Ports:
//   clk_i         clock
//   reset_i       synchronous active-high reset
//   req_data_i    num_req_p packed 32-bit commands, requester i at [32*i +: 32]
//   req_v_i       command valid per requester
//   req_ready_o   command accepted (one-hot or zero)
//   resp_data_o   read data broadcast to all requesters
//   resp_v_o      read data valid, one-hot to the owning requester
//   resp_ready_i  read data ready per requester
//   data_o        command word to the downstream link
//   v_o           downstream command valid
//   ready_i       downstream command ready
//   data_i        downstream read data
//   v_i           downstream read data valid
//   ready_o       downstream read data ready
//   stray_o       pulses when a response arrives while no read is pending
// ---------------------------------------------------------------------------
module packed_cmd_arbiter
    import packed_cmd_arbiter_pkg::*;
#(
    parameter int          num_req_p  = 2,
    parameter int          timeout_p  = 1024,
    parameter logic [31:0] err_data_p = default_err_data_lp
) (
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic [num_req_p*32-1:0] req_data_i,
    input  logic [num_req_p-1:0]    req_v_i,
    output logic [num_req_p-1:0]    req_ready_o,

    output logic [31:0]             resp_data_o,
    output logic [num_req_p-1:0]    resp_v_o,
    input  logic [num_req_p-1:0]    resp_ready_i,

    output logic [31:0]             data_o,
    output logic                    v_o,
    input  logic                    ready_i,

    input  logic [31:0]             data_i,
    input  logic                    v_i,
    output logic                    ready_o,

    output logic                    stray_o
);

    localparam int idx_w_lp   = $clog2(num_req_p);
    localparam int timer_w_lp = $clog2(timeout_p);

    arb_state_e                          state_r;
    arb_state_e                          state_n;
    logic [31:0]                         cmd_r;
    logic [idx_w_lp-1:0]                 owner_r;
    logic [timer_w_lp-1:0]               timer_r;
    logic                                armed_r;

    logic [num_req_p-1:0][31:0]          req_words;
    logic [num_req_p-1:0]                grants;
    logic [idx_w_lp-1:0]                 grant_idx;
    logic [31:0]                         sel_cmd;
    logic                                live;
    logic                                accept;
    logic                                timer_done;

    assign req_words = req_data_i;

    // armed_r stays low through reset and the first cycle after it, which
    // keeps every output except ready_o quiet during that window.
    assign live       = armed_r && !reset_i;
    assign accept     = live && (state_r == e_idle) && (|grants);
    assign timer_done = (timer_r == timer_w_lp'(timeout_p - 1));

    bsg_arb_round_robin #(
        .width_p (num_req_p)
    ) rr_arb (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .reqs_i   (req_v_i),
        .grants_o (grants),
        .yumi_i   (accept)
    );

    // Turn the one-hot grant into an index and pick that requester's command.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grants[idx_w_lp'(i)]) begin
                grant_idx = idx_w_lp'(i);
            end
        end
        sel_cmd = req_words[grant_idx];
    end

    // The timer restarts while the command is on the link, so counting begins
    // on the first e_resp cycle. It saturates so that a response held by a
    // stalled requester across the expiry cycle keeps priority over the error.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            cmd_r   <= '0;
            owner_r <= '0;
            timer_r <= '0;
            armed_r <= 1'b0;
        end else begin
            state_r <= state_n;
            armed_r <= 1'b1;
            if (accept) begin
                cmd_r   <= sel_cmd;
                owner_r <= grant_idx;
            end
            if (state_r == e_send) begin
                timer_r <= '0;
            end else if ((state_r == e_resp) && !timer_done) begin
                timer_r <= timer_r + 1'b1;
            end
        end
    end

    // Next state and outputs. Outside e_resp the link response channel is
    // always drained so a late or unexpected response can never block it.
    always_comb begin
        state_n     = state_r;
        req_ready_o = '0;
        v_o         = 1'b0;
        data_o      = '0;
        resp_v_o    = '0;
        resp_data_o = '0;
        ready_o     = 1'b1;
        stray_o     = 1'b0;

        case (state_r)
            e_idle: begin
                req_ready_o = accept ? grants : '0;
                stray_o     = v_i;
                if (accept) begin
                    state_n = e_send;
                end
            end
            e_send: begin
                v_o     = 1'b1;
                data_o  = cmd_r;
                stray_o = v_i;
                if (ready_i) begin
                    state_n = cmd_is_write(cmd_r) ? e_idle : e_resp;
                end
            end
            e_resp: begin
                resp_v_o[owner_r] = v_i;
                resp_data_o       = data_i;
                ready_o           = resp_ready_i[owner_r];
                if (v_i && resp_ready_i[owner_r]) begin
                    state_n = e_idle;
                end else if (!v_i && timer_done) begin
                    state_n = e_err;
                end
            end
            e_err: begin
                resp_v_o[owner_r] = 1'b1;
                resp_data_o       = err_data_p;
                stray_o           = v_i;
                if (resp_ready_i[owner_r]) begin
                    state_n = e_idle;
                end
            end
            default: begin
                state_n = e_idle;
            end
        endcase

        if (!live) begin
            req_ready_o = '0;
            v_o         = 1'b0;
            data_o      = '0;
            resp_v_o    = '0;
            resp_data_o = '0;
            stray_o     = 1'b0;
        end
        if (reset_i) begin
            ready_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_packed_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_packed_cmd_arbiter
//
// Plays the requesters and the downstream link around packed_cmd_arbiter.
// Expected grants come from a round-robin pick over the bench's own pending
// set, and expected responses from the data the bench itself returns (or the
// error word when it withholds the response).
// ---------------------------------------------------------------------------
module tb_packed_cmd_arbiter;
    import packed_cmd_arbiter_pkg::*;

    localparam int nreq_lp    = 3;
    localparam int iw_lp      = $clog2(nreq_lp);
    localparam int timeout_lp = 16;

    logic                    clk_i = 1'b0;
    logic                    reset_i;
    logic [nreq_lp*32-1:0]   req_data_i;
    logic [nreq_lp-1:0]      req_v_i;
    logic [nreq_lp-1:0]      req_ready_o;
    logic [31:0]             resp_data_o;
    logic [nreq_lp-1:0]      resp_v_o;
    logic [nreq_lp-1:0]      resp_ready_i;
    logic [31:0]             data_o;
    logic                    v_o;
    logic                    ready_i;
    logic [31:0]             data_i;
    logic                    v_i;
    logic                    ready_o;
    logic                    stray_o;

    logic [nreq_lp-1:0][31:0] pend_cmd;
    logic [nreq_lp-1:0]       pend_v;
    int                       model_last;
    int                       check_count;
    int                       pass_count;
    int                       fail_count;
    int                       sent0;
    int                       sent1;
    int                       pick_j;
    logic [nreq_lp-1:0]       own_tb;

    packed_cmd_arbiter #(
        .num_req_p  (nreq_lp),
        .timeout_p  (timeout_lp),
        .err_data_p (32'hDEAD_BEEF)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_data_i   (req_data_i),
        .req_v_i      (req_v_i),
        .req_ready_o  (req_ready_o),
        .resp_data_o  (resp_data_o),
        .resp_v_o     (resp_v_o),
        .resp_ready_i (resp_ready_i),
        .data_o       (data_o),
        .v_o          (v_o),
        .ready_i      (ready_i),
        .data_i       (data_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .stray_o      (stray_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic apply_stimulus();
        req_data_i = pend_cmd;
        req_v_i    = pend_v;
    endtask

    // Round-robin rule: first pending requester after the last winner.
    function automatic int rr_pick(input logic [nreq_lp-1:0] v, input int last);
        for (int k = 1; k <= nreq_lp; k++) begin
            int c;
            c = (last + k) % nreq_lp;
            if (v[iw_lp'(c)]) return c;
        end
        return -1;
    endfunction

    // One complete transaction starting from an idle arbiter: grant, command
    // on the link (with send_stall cycles of backpressure) and, for a read,
    // the response after resp_lat cycles or the error word after the timeout.
    task automatic run_txn(input int send_stall, input int resp_lat, input int rdy_stall,
                           input bit no_resp, input logic [31:0] rdata,
                           input logic [nreq_lp-1:0] late_v);
        int                 e;
        logic [31:0]        cmd;
        logic [nreq_lp-1:0] own;
        e   = rr_pick(pend_v, model_last);
        own = '0;
        if (e >= 0) own[iw_lp'(e)] = 1'b1;
        ready_i      = 1'b0;
        v_i          = 1'b0;
        data_i       = '0;
        resp_ready_i = nreq_lp'($urandom);
        apply_stimulus();
        settle();
        check_output("grant", 32'(req_ready_o), 32'(own));
        check_output("idle_resp_v", 32'(resp_v_o), 32'd0);
        check_output("idle_v_o", 32'(v_o), 32'd0);
        if (e < 0) return;
        cmd        = pend_cmd[iw_lp'(e)];
        model_last = e;
        pend_v[iw_lp'(e)] = 1'b0;
        pend_v     = pend_v | late_v;
        tick();

        for (int s = 0; s <= send_stall; s++) begin
            ready_i      = (s == send_stall);
            resp_ready_i = nreq_lp'($urandom);
            apply_stimulus();
            settle();
            check_output("send_v_o", 32'(v_o), 32'd1);
            check_output("send_data_o", data_o, cmd);
            check_output("send_no_grant", 32'(req_ready_o), 32'd0);
            check_output("send_ready_o", 32'(ready_o), 32'd1);
            tick();
        end
        ready_i = 1'b0;
        if (cmd[31]) return;

        if (no_resp) begin
            for (int t = 0; t < timeout_lp; t++) begin
                resp_ready_i = nreq_lp'($urandom);
                apply_stimulus();
                settle();
                check_output("wait_resp_v", 32'(resp_v_o), 32'd0);
                check_output("wait_ready_o", 32'(ready_o), 32'(|(resp_ready_i & own)));
                check_output("wait_no_grant", 32'(req_ready_o), 32'd0);
                tick();
            end
            for (int r = 0; r <= rdy_stall; r++) begin
                resp_ready_i = (nreq_lp'($urandom) & ~own) | ((r == rdy_stall) ? own : '0);
                apply_stimulus();
                settle();
                check_output("err_resp_v", 32'(resp_v_o), 32'(own));
                check_output("err_data", resp_data_o, 32'hDEAD_BEEF);
                check_output("err_no_grant", 32'(req_ready_o), 32'd0);
                tick();
            end
        end else begin
            for (int t = 0; t < resp_lat; t++) begin
                resp_ready_i = nreq_lp'($urandom);
                apply_stimulus();
                settle();
                check_output("lat_resp_v", 32'(resp_v_o), 32'd0);
                check_output("lat_no_grant", 32'(req_ready_o), 32'd0);
                tick();
            end
            for (int r = 0; r <= rdy_stall; r++) begin
                v_i          = 1'b1;
                data_i       = rdata;
                resp_ready_i = (nreq_lp'($urandom) & ~own) | ((r == rdy_stall) ? own : '0);
                apply_stimulus();
                settle();
                check_output("resp_v", 32'(resp_v_o), 32'(own));
                check_output("resp_data", resp_data_o, rdata);
                check_output("resp_ready_o", 32'(ready_o), 32'(r == rdy_stall));
                check_output("resp_no_grant", 32'(req_ready_o), 32'd0);
                tick();
            end
            v_i    = 1'b0;
            data_i = '0;
        end
    endtask

    initial begin
        check_count  = 0;
        pass_count   = 0;
        fail_count   = 0;
        model_last   = nreq_lp - 1;
        reset_i      = 1'b1;
        pend_cmd     = '0;
        pend_v       = '0;
        ready_i      = 1'b0;
        v_i          = 1'b0;
        data_i       = '0;
        resp_ready_i = '0;
        apply_stimulus();

        // Reset: outputs stay quiet even with a request and a response present.
        pend_v[0]   = 1'b1;
        pend_cmd[0] = {1'b1, 23'h000010, 8'hA5};
        v_i         = 1'b1;
        apply_stimulus();
        tick();
        tick();
        settle();
        check_output("rst_req_ready", 32'(req_ready_o), 32'd0);
        check_output("rst_v_o", 32'(v_o), 32'd0);
        check_output("rst_data_o", data_o, 32'd0);
        check_output("rst_resp_v", 32'(resp_v_o), 32'd0);
        check_output("rst_resp_data", resp_data_o, 32'd0);
        check_output("rst_ready_o", 32'(ready_o), 32'd0);
        check_output("rst_stray", 32'(stray_o), 32'd0);
        tick();
        reset_i = 1'b0;
        v_i     = 1'b0;
        settle();
        check_output("post_rst_req_ready", 32'(req_ready_o), 32'd0);
        check_output("post_rst_v_o", 32'(v_o), 32'd0);
        check_output("post_rst_ready_o", 32'(ready_o), 32'd1);
        tick();

        // Single write from requester 0.
        $display("[TB] single write");
        run_txn(0, 0, 0, 1'b0, 32'd0, '0);
        check_output("single_write_cmd", pend_cmd[0], 32'h8000_10A5);

        // Fairness: requesters 0 and 1 each keep four writes queued.
        $display("[TB] round-robin fairness");
        sent0 = 0;
        sent1 = 0;
        pend_v      = 3'b011;
        pend_cmd[0] = {1'b1, 23'h000100, 8'h00};
        pend_cmd[1] = {1'b1, 23'h000200, 8'h00};
        for (int n = 0; n < 8; n++) begin
            run_txn(0, 0, 0, 1'b0, 32'd0, '0);
            if (model_last == 0) begin
                sent0++;
                if (sent0 < 4) begin
                    pend_v[0]   = 1'b1;
                    pend_cmd[0] = {1'b1, 23'(32'h100 + n), 8'(n)};
                end
            end else begin
                sent1++;
                if (sent1 < 4) begin
                    pend_v[1]   = 1'b1;
                    pend_cmd[1] = {1'b1, 23'(32'h200 + n), 8'(n)};
                end
            end
        end

        // Read routing: req1 reads, req0 raises a read while req1 is in flight.
        $display("[TB] read routing");
        pend_v      = 3'b010;
        pend_cmd[1] = {1'b0, 23'h000020, 8'h00};
        pend_cmd[0] = {1'b0, 23'h000030, 8'h00};
        run_txn(0, 5, 2, 1'b0, 32'h1234_5678, 3'b001);
        run_txn(1, 0, 0, 1'b0, 32'hA0A0_0001, '0);

        // Response arriving on the expiry cycle wins over the error.
        $display("[TB] response on expiry cycle");
        pend_v      = 3'b100;
        pend_cmd[2] = {1'b0, 23'h000044, 8'h00};
        run_txn(0, timeout_lp - 1, 2, 1'b0, 32'h5555_AAAA, '0);

        // Timeout, then a late response is drained as stray.
        $display("[TB] timeout");
        pend_v      = 3'b001;
        pend_cmd[0] = {1'b0, 23'h000050, 8'h00};
        run_txn(0, 0, 1, 1'b1, 32'd0, '0);
        v_i    = 1'b1;
        data_i = 32'hCAFE_0001;
        apply_stimulus();
        settle();
        check_output("stray_pulse", 32'(stray_o), 32'd1);
        check_output("stray_ready_o", 32'(ready_o), 32'd1);
        check_output("stray_resp_v", 32'(resp_v_o), 32'd0);
        tick();
        v_i    = 1'b0;
        data_i = '0;
        settle();
        check_output("stray_end", 32'(stray_o), 32'd0);
        tick();

        // Downstream backpressure holds the command stable.
        $display("[TB] backpressure");
        pend_v      = 3'b010;
        pend_cmd[1] = 32'h8ABC_DE12;
        run_txn(10, 0, 0, 1'b0, 32'd0, '0);

        // Reset in the middle of a read.
        $display("[TB] reset mid-read");
        pend_v      = 3'b010;
        pend_cmd[1] = {1'b0, 23'h000044, 8'h00};
        ready_i     = 1'b0;
        apply_stimulus();
        settle();
        own_tb = 3'b010;
        check_output("mid_grant", 32'(req_ready_o), 32'(own_tb));
        model_last = 1;
        pend_v     = '0;
        tick();
        ready_i = 1'b1;
        apply_stimulus();
        settle();
        check_output("mid_v_o", 32'(v_o), 32'd1);
        tick();
        ready_i = 1'b0;
        tick();
        tick();
        reset_i     = 1'b1;
        pend_v      = 3'b011;
        pend_cmd[0] = 32'h8000_0111;
        pend_cmd[1] = 32'h8000_0222;
        apply_stimulus();
        settle();
        check_output("mid_rst_resp_v", 32'(resp_v_o), 32'd0);
        check_output("mid_rst_ready_o", 32'(ready_o), 32'd0);
        check_output("mid_rst_req_ready", 32'(req_ready_o), 32'd0);
        tick();
        reset_i    = 1'b0;
        model_last = nreq_lp - 1;
        settle();
        check_output("mid_post_req_ready", 32'(req_ready_o), 32'd0);
        check_output("mid_post_ready_o", 32'(ready_o), 32'd1);
        tick();
        v_i    = 1'b1;
        data_i = 32'h0BAD_0BAD;
        pend_v = '0;
        apply_stimulus();
        settle();
        check_output("late_stray", 32'(stray_o), 32'd1);
        check_output("late_resp_v", 32'(resp_v_o), 32'd0);
        tick();
        v_i    = 1'b0;
        data_i = '0;
        pend_v = 3'b011;
        run_txn(0, 0, 0, 1'b0, 32'd0, '0);
        check_output("post_rst_first_grant", 32'(model_last), 32'd0);
        run_txn(0, 0, 0, 1'b0, 32'd0, '0);

        // Randomised traffic.
        $display("[TB] random traffic");
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < nreq_lp; i++) begin
                if (!pend_v[iw_lp'(i)] && ($urandom_range(1, 0) == 1)) begin
                    pend_v[iw_lp'(i)]   = 1'b1;
                    pend_cmd[iw_lp'(i)] = $urandom;
                end
            end
            if (pend_v == '0) begin
                pick_j = int'($urandom_range(nreq_lp - 1, 0));
                pend_v[iw_lp'(pick_j)]   = 1'b1;
                pend_cmd[iw_lp'(pick_j)] = $urandom;
            end
            run_txn(int'($urandom_range(3, 0)), int'($urandom_range(8, 0)),
                    int'($urandom_range(3, 0)), ($urandom_range(7, 0) == 0),
                    $urandom, '0);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
